fb_trig_sequencer: RTL and testbench
====================================

Name: fb_trig_sequencer

Overview:
- Per-pulse timing sequencer for the FONT5 feedback datapath; runs in the clk357 domain.
- On an armed trigger it waits a programmable delay and opens a sample-store window of programmable length.
- Inside the window it issues the store strobe, the delay-trigger pulse and three delay-calculation strobes at programmable sample offsets.
- It is the only source of run/store_strb/delay_calc_strb1..3/delay_trig for the ADC capture and DAC feedback logic.

Parameters:
CNT_W, 14, width of all delay/length/offset fields and of the sample counter
N_CALC, 3, number of delay_calc strobes (fixed at 3; ports are named 1..3)

Ports:
clk357  input  1  357 MHz system clock
rst  input  1  synchronous active-high reset
trig_in  input  1  beam trigger, already synchronised to clk357; rising edge is the event
arm  input  1  one-cycle request to arm; clears trig_missed
auto_rearm  input  1  1: return to ARMED after DONE instead of IDLE
trig_delay  input  CNT_W  cycles from trigger edge to first store cycle
store_len  input  CNT_W  store window length in cycles
calc_off1  input  CNT_W  sample index for delay_calc_strb1
calc_off2  input  CNT_W  sample index for delay_calc_strb2
calc_off3  input  CNT_W  sample index for delay_calc_strb3
armed  output  1  high in ARMED
run  output  1  high in DELAY and STORE
store_strb  output  1  high for every STORE cycle
delay_trig  output  1  one-cycle pulse on the first STORE cycle
delay_calc_strb1  output  1  one-cycle pulse at sample_idx==calc_off1
delay_calc_strb2  output  1  one-cycle pulse at sample_idx==calc_off2
delay_calc_strb3  output  1  one-cycle pulse at sample_idx==calc_off3
sample_idx  output  CNT_W  index within the store window; 0 outside it
done  output  1  one-cycle pulse in DONE
trig_missed  output  1  sticky: a trigger edge arrived while not ARMED

Behaviour:
- Reset: clock is clk357; reset is synchronous and active-high (rst).
  - State goes to IDLE; the trig_in edge-detect register clears to 0.
  - All outputs are 0 from the cycle after rst is sampled high.
  - rst overrides every other input, including mid-window.
- Edge detect: edge = trig_in & ~trig_q, where trig_q is trig_in registered.
- States: IDLE, ARMED, DELAY, STORE, DONE.
- IDLE -> ARMED when arm=1.
- ARMED on edge at cycle T:
  - Latch trig_delay, store_len and calc_off1..3 into shadow registers.
  - Go to DELAY at T+1; if the latched trig_delay==0, go directly to STORE at T+1.
  - Config changes after T have no effect on the current window.
- DELAY:
  - Counter starts at 0 and increments each cycle.
  - When counter==trig_delay-1, go to STORE.
  - First STORE cycle is T+1+trig_delay in all cases.
- STORE:
  - store_strb=1 and sample_idx = 0..store_len-1, incrementing each cycle.
  - Go to DONE after the cycle with sample_idx==store_len-1.
  - If the latched store_len==0, skip STORE entirely: no store_strb, no delay_trig, no calc strobes; go to DONE at the cycle STORE would have begun.
- delay_trig: 1 only on the cycle with STORE and sample_idx==0.
- delay_calc_strbK: 1 on the STORE cycle where sample_idx==calc_offK.
  - calc_offK >= store_len means that strobe never fires.
  - Equal offsets fire their strobes in the same cycle.
- DONE: lasts one cycle with done=1, then goes to ARMED if auto_rearm=1, else IDLE.
- Output timing: all outputs are registered and valid in the cycle of the state they describe.
  - armed=1 exactly in ARMED; run=1 exactly in DELAY and STORE.
- arm while in DELAY/STORE/DONE: the state transition is ignored, but trig_missed still clears.
- arm in ARMED: no effect.
- trig_missed:
  - Set on an edge in any state other than ARMED, including edges during DELAY/STORE.
  - Cleared only by arm=1 or rst; set wins if an edge and arm coincide in a non-ARMED state.
- Edge in the same cycle as arm in IDLE: the trigger is missed (trig_missed=1), and the block enters ARMED.
- Counter width: internal counters are CNT_W bits and never wrap within legal config; max trig_delay and store_len are 2^CNT_W-1.

Test Plan:
- Reset: rst=1 for 3 cycles -> all outputs 0, trig_missed=0. Then arm, trig_delay=5, store_len=8, offsets 0/3/7; edge at T -> run T+1..T+13, store_strb T+6..T+13, delay_trig and calc_strb1 at T+6, calc_strb2 at T+9, calc_strb3 at T+13, done at T+14, IDLE at T+15.
- Zero delay: trig_delay=0, store_len=4 -> store_strb T+1..T+4, sample_idx 0,1,2,3. Zero length: store_len=0 -> no store_strb or delay_trig, done at T+1+trig_delay.
- Out-of-range offsets: calc_off2=calc_off3=2, calc_off1=10 with store_len=8 -> strb2 and strb3 in the same cycle, strb1 never.
- Config latch and missed trigger: change store_len from 8 to 2 at T+3 -> still 8 store cycles. Second edge at T+7 -> trig_missed=1, current window unaffected; arm clears trig_missed.
- Auto-rearm: auto_rearm=1, three edges spaced 30 cycles, trig_delay=4, store_len=10 -> three identical windows, armed=1 between them, trig_missed stays 0.
- Mid-window reset: rst asserted at sample_idx==3 -> next cycle all outputs 0 and state IDLE. A following edge without arm -> trig_missed=1, no window.

Source files
------------

// File: rtl/fb_trig_sequencer.sv
// Per-pulse trigger sequencer: arms, delays from the trigger edge, then opens a store window with timed strobes.
// Latency: first store cycle is trig_delay+1 cycles after the sampled trigger edge; all outputs registered.
// Backpressure: none; free-running timing source, triggers outside ARMED are flagged in trig_missed.
module fb_trig_sequencer #(
    parameter int CNT_W  = 14,
    parameter int N_CALC = 3
) (
    input  logic             clk357,
    input  logic             rst,
    input  logic             trig_in,
    input  logic             arm,
    input  logic             auto_rearm,
    input  logic [CNT_W-1:0] trig_delay,
    input  logic [CNT_W-1:0] store_len,
    input  logic [CNT_W-1:0] calc_off1,
    input  logic [CNT_W-1:0] calc_off2,
    input  logic [CNT_W-1:0] calc_off3,
    output logic             armed,
    output logic             run,
    output logic             store_strb,
    output logic             delay_trig,
    output logic             delay_calc_strb1,
    output logic             delay_calc_strb2,
    output logic             delay_calc_strb3,
    output logic [CNT_W-1:0] sample_idx,
    output logic             done,
    output logic             trig_missed
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_DELAY,
        S_STORE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             trig_q;
    logic             trig_edge;
    logic             load;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] sh_delay;
    logic [CNT_W-1:0] sh_len;
    logic [CNT_W-1:0] cfg_off    [N_CALC];
    logic [CNT_W-1:0] sh_off     [N_CALC];
    logic [CNT_W-1:0] sh_off_nxt [N_CALC];

    logic              armed_nxt;
    logic              run_nxt;
    logic              store_nxt;
    logic              dtrig_nxt;
    logic [N_CALC-1:0] calc_nxt;
    logic [N_CALC-1:0] calc_q;
    logic [CNT_W-1:0]  idx_nxt;
    logic              done_nxt;

    assign trig_edge  = trig_in & ~trig_q;
    assign load       = (state == S_ARMED) && trig_edge;
    assign cfg_off[0] = calc_off1;
    assign cfg_off[1] = calc_off2;
    assign cfg_off[2] = calc_off3;

    // Offsets seen by the output logic must already be the new ones when
    // a zero-delay window starts in the cycle right after the edge.
    always_comb begin
        for (int i = 0; i < N_CALC; i++) begin
            sh_off_nxt[i] = load ? cfg_off[i] : sh_off[i];
        end
    end

    always_ff @(posedge clk357) begin
        if (rst) begin
            state    <= S_IDLE;
            trig_q   <= 1'b0;
            cnt      <= '0;
            sh_delay <= '0;
            sh_len   <= '0;
            for (int i = 0; i < N_CALC; i++) begin
                sh_off[i] <= '0;
            end
        end else begin
            state  <= state_nxt;
            trig_q <= trig_in;
            cnt    <= cnt_nxt;
            if (load) begin
                sh_delay <= trig_delay;
                sh_len   <= store_len;
            end
            for (int i = 0; i < N_CALC; i++) begin
                sh_off[i] <= sh_off_nxt[i];
            end
        end
    end

    // One counter serves both DELAY and STORE; it restarts at 0 on entry to each.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (arm) state_nxt = S_ARMED;
            end
            S_ARMED: begin
                if (trig_edge) begin
                    cnt_nxt = '0;
                    if (trig_delay != '0)     state_nxt = S_DELAY;
                    else if (store_len != '0) state_nxt = S_STORE;
                    else                      state_nxt = S_DONE;
                end
            end
            S_DELAY: begin
                if (cnt == sh_delay - ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = (sh_len != '0) ? S_STORE : S_DONE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            S_STORE: begin
                if (cnt == sh_len - ONE) begin
                    cnt_nxt   = '0;
                    state_nxt = S_DONE;
                end else begin
                    cnt_nxt = cnt + ONE;
                end
            end
            S_DONE: begin
                cnt_nxt   = '0;
                state_nxt = auto_rearm ? S_ARMED : S_IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line
    // up with the state they describe.
    always_comb begin
        armed_nxt = (state_nxt == S_ARMED);
        run_nxt   = (state_nxt == S_DELAY) || (state_nxt == S_STORE);
        store_nxt = (state_nxt == S_STORE);
        idx_nxt   = store_nxt ? cnt_nxt : '0;
        dtrig_nxt = store_nxt && (cnt_nxt == '0);
        done_nxt  = (state_nxt == S_DONE);
        for (int i = 0; i < N_CALC; i++) begin
            calc_nxt[i] = store_nxt && (cnt_nxt == sh_off_nxt[i]);
        end
    end

    always_ff @(posedge clk357) begin
        if (rst) begin
            armed       <= 1'b0;
            run         <= 1'b0;
            store_strb  <= 1'b0;
            delay_trig  <= 1'b0;
            calc_q      <= '0;
            sample_idx  <= '0;
            done        <= 1'b0;
            trig_missed <= 1'b0;
        end else begin
            armed      <= armed_nxt;
            run        <= run_nxt;
            store_strb <= store_nxt;
            delay_trig <= dtrig_nxt;
            calc_q     <= calc_nxt;
            sample_idx <= idx_nxt;
            done       <= done_nxt;
            if (trig_edge && (state != S_ARMED)) trig_missed <= 1'b1;
            else if (arm)                        trig_missed <= 1'b0;
        end
    end

    assign delay_calc_strb1 = calc_q[0];
    assign delay_calc_strb2 = calc_q[1];
    assign delay_calc_strb3 = calc_q[2];

endmodule

// File: tb/tb_fb_trig_sequencer.sv
// Directed bench for fb_trig_sequencer: per-cycle output vectors checked against hand-derived window timing.
module tb_fb_trig_sequencer;

    localparam int W = 14;

    logic         clk357 = 1'b0;
    logic         rst = 1'b1;
    logic         trig_in = 1'b0;
    logic         arm = 1'b0;
    logic         auto_rearm = 1'b0;
    logic [W-1:0] trig_delay = '0;
    logic [W-1:0] store_len = '0;
    logic [W-1:0] calc_off1 = '0;
    logic [W-1:0] calc_off2 = '0;
    logic [W-1:0] calc_off3 = '0;
    logic         armed, run, store_strb, delay_trig;
    logic         delay_calc_strb1, delay_calc_strb2, delay_calc_strb3;
    logic [W-1:0] sample_idx;
    logic         done, trig_missed;

    int n_chk  = 0;
    int n_pass = 0;

    fb_trig_sequencer #(.CNT_W(W), .N_CALC(3)) dut (
        .clk357(clk357), .rst(rst), .trig_in(trig_in), .arm(arm),
        .auto_rearm(auto_rearm), .trig_delay(trig_delay), .store_len(store_len),
        .calc_off1(calc_off1), .calc_off2(calc_off2), .calc_off3(calc_off3),
        .armed(armed), .run(run), .store_strb(store_strb), .delay_trig(delay_trig),
        .delay_calc_strb1(delay_calc_strb1), .delay_calc_strb2(delay_calc_strb2),
        .delay_calc_strb3(delay_calc_strb3), .sample_idx(sample_idx),
        .done(done), .trig_missed(trig_missed)
    );

    always #5 clk357 = ~clk357;

    // {armed,run,store,dtrig,c1,c2,c3,done,missed,idx}
    logic [W+8:0] obs;
    assign obs = {armed, run, store_strb, delay_trig, delay_calc_strb1,
                  delay_calc_strb2, delay_calc_strb3, done, trig_missed, sample_idx};

    task automatic tick();
        @(posedge clk357);
        #1;
    endtask

    // Expected outputs k cycles after the trigger-edge cycle, for delay d and length len.
    function automatic logic [W+8:0] exp_vec(input int k, input int d, input int len,
                                             input int o1, input int o2, input int o3,
                                             input bit rearm, input bit missed);
        bit st;
        int idx;
        logic [W-1:0] idx_w;
        st    = (len > 0) && (k >= d + 1) && (k <= d + len);
        idx   = st ? (k - d - 1) : 0;
        idx_w = idx[W-1:0];
        return {(k == 0) || (rearm && (k > d + len + 1)),
                (k >= 1) && (k <= d + len),
                st, st && (idx == 0), st && (idx == o1), st && (idx == o2), st && (idx == o3),
                (k == d + len + 1), missed, idx_w};
    endfunction

    task automatic setup(input int d, input int len, input int o1, input int o2, input int o3);
        trig_delay = d[W-1:0];
        store_len  = len[W-1:0];
        calc_off1  = o1[W-1:0];
        calc_off2  = o2[W-1:0];
        calc_off3  = o3[W-1:0];
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_chk++;
        if (armed !== 1'b1) $display("FAIL arm_enter: armed=%b required 1", armed);
        else n_pass++;
    endtask

    task automatic test_reset();
        trig_in = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_chk++;
            if (obs !== '0) $display("FAIL reset_outputs cyc%0d: got %h required 0", i, obs);
            else n_pass++;
        end
        rst = 1'b0;
        tick();
        n_chk++;
        if (obs !== '0) $display("FAIL reset_idle: got %h required 0", obs);
        else n_pass++;
    endtask

    task automatic test_basic();
        logic [W+8:0] e;
        setup(5, 8, 0, 3, 7);
        trig_in = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            trig_in = 1'b0;
            e = exp_vec(k, 5, 8, 0, 3, 7, 1'b0, 1'b0);
            n_chk++;
            if (obs !== e) $display("FAIL basic k=%0d: got %h required %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_zero_delay();
        logic [W+8:0] e;
        setup(0, 4, 1, 2, 3);
        trig_in = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            tick();
            trig_in = 1'b0;
            e = exp_vec(k, 0, 4, 1, 2, 3, 1'b0, 1'b0);
            n_chk++;
            if (obs !== e) $display("FAIL zero_delay k=%0d: got %h required %h", k, obs, e);
            else n_pass++;
        end
    endtask

    task automatic test_zero_len();
        logic [W+8:0] e;
        int dl [2] = '{3, 0};
        for (int c = 0; c < 2; c++) begin
            setup(dl[c], 0, 0, 0, 0);
            trig_in = 1'b1;
            for (int k = 1; k <= 6; k++) begin
                tick();
                trig_in = 1'b0;
                e = exp_vec(k, dl[c], 0, 0, 0, 0, 1'b0, 1'b0);
                n_chk++;
                if (obs !== e) $display("FAIL zero_len d=%0d k=%0d: got %h required %h", dl[c], k, obs, e);
                else n_pass++;
            end
        end
    endtask

    task automatic test_offsets();
        logic [W+8:0] e;
        int n1 = 0;
        setup(2, 8, 10, 2, 2);
        trig_in = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            tick();
            trig_in = 1'b0;
            if (delay_calc_strb1) n1++;
            e = exp_vec(k, 2, 8, 10, 2, 2, 1'b0, 1'b0);
            n_chk++;
            if (obs !== e) $display("FAIL offsets k=%0d: got %h required %h", k, obs, e);
            else n_pass++;
        end
        n_chk++;
        if (n1 !== 0) $display("FAIL offsets_strb1_count: got %0d required 0", n1);
        else n_pass++;
    endtask

    task automatic test_latch_missed();
        logic [W+8:0] e;
        setup(5, 8, 0, 3, 7);
        trig_in = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            tick();
            trig_in = (k == 7);
            if (k == 3) begin
                store_len  = 2;
                trig_delay = 1;
                calc_off1  = 5;
            end
            e = exp_vec(k, 5, 8, 0, 3, 7, 1'b0, k >= 8);
            n_chk++;
            if (obs !== e) $display("FAIL latch_missed k=%0d: got %h required %h", k, obs, e);
            else n_pass++;
        end
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_chk++;
        if ({armed, trig_missed} !== 2'b10)
            $display("FAIL arm_clears_missed: armed,missed=%b required 10", {armed, trig_missed});
        else n_pass++;
    endtask

    task automatic test_auto_rearm();
        logic [W+8:0] e;
        auto_rearm = 1'b1;
        setup(4, 10, 1, 5, 9);
        for (int w = 0; w < 3; w++) begin
            trig_in = 1'b1;
            for (int k = 1; k <= 30; k++) begin
                tick();
                trig_in = 1'b0;
                e = exp_vec(k, 4, 10, 1, 5, 9, 1'b1, 1'b0);
                n_chk++;
                if (obs !== e) $display("FAIL auto_rearm w=%0d k=%0d: got %h required %h", w, k, obs, e);
                else n_pass++;
            end
        end
        auto_rearm = 1'b0;
    endtask

    task automatic test_mid_reset();
        logic [W+8:0] e;
        setup(2, 8, 0, 1, 2);
        trig_in = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            tick();
            trig_in = 1'b0;
            e = exp_vec(k, 2, 8, 0, 1, 2, 1'b0, 1'b0);
            n_chk++;
            if (obs !== e) $display("FAIL mid_reset_pre k=%0d: got %h required %h", k, obs, e);
            else n_pass++;
        end
        n_chk++;
        if (sample_idx !== 14'd3) $display("FAIL mid_reset_idx: got %0d required 3", sample_idx);
        else n_pass++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (obs !== '0) $display("FAIL mid_reset_clear: got %h required 0", obs);
        else n_pass++;
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            n_chk++;
            if ({armed, run, store_strb, done, trig_missed} !== 5'b00001)
                $display("FAIL unarmed_edge k=%0d: got %b required 00001", k,
                         {armed, run, store_strb, done, trig_missed});
            else n_pass++;
        end
        // arm together with an edge in IDLE: edge is missed, block still arms
        arm = 1'b1;
        tick();
        arm = 1'b0;
        trig_in = 1'b1;
        tick();
        trig_in = 1'b0;
        tick();
        arm = 1'b1;
        trig_in = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        arm = 1'b0;
        tick();
        trig_in = 1'b1;
        arm = 1'b1;
        tick();
        trig_in = 1'b0;
        arm = 1'b0;
        n_chk++;
        if ({armed, run, trig_missed} !== 3'b101)
            $display("FAIL arm_with_edge: armed,run,missed=%b required 101", {armed, run, trig_missed});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_delay();
        test_zero_len();
        test_offsets();
        test_latch_missed();
        test_auto_rearm();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
